// File: rtl/spi_reg_writer.sv
// spi_reg_writer
// Serialises one register write per accepted start request as a 16-bit SPI
// mode-0 frame: write flag (1), 7-bit address, 8-bit data, MSB first.
// sclk idles low, data is launched on sclk falling edges, and cs is active low.
// Each frame is followed by a CS_GAP-cycle gap with cs high. After the gap,
// done pulses for one cycle.
//
// Parameters
//   HALF_PERIOD  clk cycles per sclk half-period (2..255)
//   CS_GAP       clk cycles cs is held high after a frame before done (1..255)
//
// Ports
//   clk    in   system clock, all logic on its rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request a write frame; only looked at while busy=0
//   addr   in   [6:0] register address, captured on acceptance
//   wdata  in   [7:0] register data, captured on acceptance
//   sclk   out  serial clock (idle low)
//   cs     out  chip select, active low (idle high)
//   sdi    out  serial data to the peripheral (idle low)
//   busy   out  high while a frame or its trailing gap is in progress
//   done   out  one-cycle pulse once frame and gap have completed
module spi_reg_writer #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       sclk,
  output logic       cs,
  output logic       sdi,
  output logic       busy,
  output logic       done
);

  // One shared cycle counter serves both the sclk half-periods and the cs gap.
  localparam int MAX_CNT = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_BIT = 5'd15;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SCK_HIGH = 3'd2;
  localparam logic [2:0] S_SCK_LOW  = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [15:0]      shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;
  logic             sdi_q, sdi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             phase_end;
  logic             frame_active;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    done_d       = 1'b0;
    phase_end    = (cnt_q == HP_LAST);

    case (state_q)
      S_IDLE: begin
        // The done cycle is itself IDLE, so a start held high there
        // launches the next frame straight away.
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = {1'b1, addr, wdata};
        end
      end

      S_SETUP: begin
        if (phase_end) begin
          state_d = S_SCK_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SCK_HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          bit_d = bit_q + 5'd1;
          if (bit_q == LAST_BIT) begin
            // The last bit stays on sdi through HOLD, so the register does not shift.
            state_d = S_HOLD;
          end else begin
            // Shifting here makes the next bit appear in the first
            // SCK_LOW cycle, which launches it on the falling edge.
            state_d = S_SCK_LOW;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SCK_LOW: begin
        if (phase_end) begin
          state_d = S_SCK_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLD: begin
        if (phase_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        shift_d = '0;
      end
    endcase

    // Outputs are decoded from the next state and then registered.
    // They line up with the state and have no input-to-output combinational path.
    frame_active = (state_d == S_SETUP) || (state_d == S_SCK_HIGH) ||
                   (state_d == S_SCK_LOW) || (state_d == S_HOLD);
    sclk_d = (state_d == S_SCK_HIGH);
    cs_d   = ~frame_active;
    sdi_d  = frame_active & shift_d[15];
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      sdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      sdi_q   <= sdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign sdi  = sdi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/spi_reg_writer.md
SPI_REG_WRITER -- requirements
Module: spi_reg_writer

Interface
REQ-001 Parameter HALF_PERIOD, default 4, clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter CS_GAP, default 4, clk cycles cs held high after a frame before done; legal range 1..255.
REQ-003 clk  input  1  system clock; the single clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request one write frame; sampled only when busy=0.
REQ-006 addr  input  7  target register address, captured on accepted start.
REQ-007 wdata  input  8  register write data, captured on accepted start.
REQ-008 sclk  output  1  serial clock; idles low (mode 0).
REQ-009 cs  output  1  chip select, active-low; idles high.
REQ-010 sdi  output  1  serial data to the peripheral; idles low.
REQ-011 busy  output  1  high while a frame or its trailing gap is in progress.
REQ-012 done  output  1  one-cycle pulse when a frame and its gap have completed.

Function
REQ-013 Frame = 16 bits, MSB first: bit15=1 (write flag), bits14:8=addr, bits7:0=wdata.
REQ-014 Start accepted on a rising edge where start=1 and busy=0, including the cycle done is high; frame captured into an internal 16-bit shift register.
REQ-015 start while busy=1 ignored; addr/wdata changes after acceptance do not affect the frame in flight.
REQ-016 States: IDLE, SETUP, SCK_HIGH, SCK_LOW, HOLD, GAP; one cycle counter sized for max(HALF_PERIOD, CS_GAP); one 5-bit bit counter.
REQ-017 IDLE -> SETUP on acceptance; first SETUP cycle: cs=0, sdi=bit15, sclk=0, busy=1.
REQ-018 SETUP lasts HALF_PERIOD cycles, then SCK_HIGH.
REQ-019 SCK_HIGH: sclk=1 for HALF_PERIOD cycles; sdi stable throughout.
REQ-020 After SCK_HIGH: if fewer than 16 bits sent -> SCK_LOW; after the 16th bit -> HOLD.
REQ-021 SCK_LOW: sclk=0 for HALF_PERIOD cycles; sdi updates to next bit in the first SCK_LOW cycle (falling-edge launch), then -> SCK_HIGH.
REQ-022 HOLD: sclk=0, cs=0, sdi=bit0 held for HALF_PERIOD cycles, then GAP.
REQ-023 GAP: cs=1, sclk=0, sdi=0, busy=1 for CS_GAP cycles, then IDLE with done=1 for exactly one cycle and busy=0.
REQ-024 Exactly 16 sclk rising edges per frame; busy high for exactly 33*HALF_PERIOD + CS_GAP cycles.
REQ-025 Address values 5..127 transmitted unmodified; no range checking in this block.
REQ-026 All outputs registered; no combinational path from inputs to outputs.
REQ-027 Back-to-back: start held high through done cycle launches the next frame with cs high for at least CS_GAP+1 cycles between frames.

Reset
REQ-028 rst_n=0 at a rising edge forces IDLE, sclk=0, cs=1, sdi=0, busy=0, done=0, counters and shift register to 0.
REQ-029 Reset mid-frame aborts immediately: cs returns high on the same edge, no done pulse, frame discarded.
REQ-030 Frame acceptance not possible in a cycle where rst_n=0; first acceptance possible on the first edge with rst_n=1.

Verification
REQ-031 Reset: hold rst_n=0 for 3 cycles with start=1 -> sclk=0, cs=1, sdi=0, busy=0, done=0 throughout.
REQ-032 Single write, defaults: addr=0x02, wdata=0xA5 -> sdi sampled at 16 sclk rising edges = 0x82A5; busy high 136 cycles; done pulse in cycle 137 after acceptance.
REQ-033 Ignored start: pulse start with addr=0x7F during a frame carrying addr=0x01, wdata=0x3C -> frame remains 0x813C; only one done.
REQ-034 Back-to-back: start held high, frames (0x00,0x11) then (0x04,0xFF) -> 0x8011 then 0x84FF; cs high >= 5 cycles between; two done pulses 137 cycles apart.
REQ-035 Mid-frame reset: rst_n=0 after 8th sclk rising edge -> cs=1 next edge, no done; fresh frame afterwards transmits correctly.
REQ-036 End-to-end: drive the team's SPI peripheral with HALF_PERIOD=4 writing 0x5A to addresses 0..4 -> its five registers read 0x5A; write to address 5 -> no register changes.
